// File: rtl/bscan_hub.sv
// bscan_hub: shares one BSCAN user chain among NUM_PORTS bridges, port chosen by sniffed command scans
module bscan_hub #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W = $clog2(NUM_PORTS),
    parameter logic [7:0] KEY = 8'hA5,
    parameter int DEFAULT_PORT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              bscan_i,
    output logic                    tdo_o,
    output logic [10*NUM_PORTS-1:0] bscan_o,
    input  logic [NUM_PORTS-1:0]    tdo_i,
    output logic [PORT_W-1:0]       active_port_o,
    output logic                    cmd_ok_o,
    output logic                    cmd_err_o
);
    localparam int HW = 8 + PORT_W;
    typedef enum logic [1:0] {IDLE, HDR, ARMED, PASS} state_t;
    state_t state, state_n;
    logic [4:0] bit_cnt, cnt_n, cnt_inc;
    logic [HW-1:0] hdr, hdr_n, hdr_sh;
    logic [PORT_W-1:0] port_n, idx;
    logic ok_n, err_n, cap, sh, upd, treset, idx_ok;
    assign cap = bscan_i[5] & bscan_i[9];
    assign sh = bscan_i[5] & bscan_i[4];
    assign upd = bscan_i[5] & bscan_i[0];
    assign treset = bscan_i[7];
    assign cnt_inc = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
    assign hdr_sh = {bscan_i[2], hdr[HW-1:1]};
    assign idx = hdr[HW-1:8];
    assign idx_ok = {1'b0, idx} < (PORT_W+1)'(NUM_PORTS);
    assign tdo_o = tdo_i[active_port_o];
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign bscan_o[10*p +: 10] = {bscan_i[9:6], bscan_i[5] & (active_port_o == PORT_W'(p)), bscan_i[4:0]};
    end
    always_comb begin
        state_n = state;
        cnt_n = bit_cnt;
        hdr_n = hdr;
        port_n = active_port_o;
        ok_n = 1'b0;
        err_n = 1'b0;
        if (treset) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (cap) begin
            state_n = HDR;
            cnt_n = '0;
            hdr_n = '0;
        end else if (upd) begin
            state_n = IDLE;
            if (state == ARMED) begin
                ok_n = idx_ok;
                err_n = !idx_ok;
                port_n = idx_ok ? idx : active_port_o;
            end
        end else if (sh && state != IDLE) begin
            cnt_n = cnt_inc;
            if (state == HDR) begin
                hdr_n = hdr_sh;
                // key is complete once 8 bits are in; it sits in the top byte until the index follows
                state_n = (cnt_inc == 5'd8 && hdr_sh[HW-1 -: 8] != KEY) ? PASS :
                          (cnt_inc == 5'(HW)) ? ARMED : HDR;
            end else begin
                state_n = PASS;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            hdr <= '0;
            active_port_o <= PORT_W'(DEFAULT_PORT);
            cmd_ok_o <= 1'b0;
            cmd_err_o <= 1'b0;
        end else begin
            state <= state_n;
            bit_cnt <= cnt_n;
            hdr <= hdr_n;
            active_port_o <= port_n;
            cmd_ok_o <= ok_n;
            cmd_err_o <= err_n;
        end
    end
endmodule
